// File: rtl/inst_sram_axi_rbridge.sv
`default_nettype none
// ============================================================================
//  Module      : inst_sram_axi_rbridge
//  Description : Responder for the instruction-fetch SRAM-like interface.
//                Each accepted fetch request becomes one single-beat AXI read.
//                Read data is returned in request order. Beats that belong to
//                requests already in flight when a flush arrives are dropped.
//
//  Ports       : clk, rst_n                 clock, async active-low reset
//                inst_sram_req_i/raddr_i    fetch request and address
//                inst_sram_addr_ok_o        request accepted this cycle
//                inst_sram_data_ok_o/rdata  instruction word returned
//                cancel_i                   flush: drop all outstanding beats
//                ar*_o, arready_i           AXI read-address channel
//                rvalid_i, rdata_i, rresp_i,
//                rlast_i, rready_o          AXI read-data channel
//                bus_error_o                sticky error flag
//
//  Optional    : `define INST_RBRIDGE_PERF_CNT_EN adds perf_req_cnt_o,
//                perf_stall_cnt_o and perf_drop_cnt_o (32-bit, wrapping).
//
//  Revision    : 1.0  initial release
// ============================================================================
module inst_sram_axi_rbridge #(
    parameter int unsigned MAX_OUTST = 2,        // 1..7
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_sram_req_i,
    input  logic [31:0] inst_sram_raddr_i,
    output logic        inst_sram_addr_ok_o,
    output logic        inst_sram_data_ok_o,
    output logic [31:0] inst_sram_rdata_o,
    input  logic        cancel_i,
    output logic        arvalid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arid_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    input  logic        arready_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    output logic        rready_o,
`ifdef INST_RBRIDGE_PERF_CNT_EN
    output logic [31:0] perf_req_cnt_o,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_drop_cnt_o,
`endif
    output logic        bus_error_o
);

    localparam logic [2:0] C_MAX_OUTST = 3'(MAX_OUTST);

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_e;

    ar_state_e   ar_state_q, ar_state_d;
    logic [31:0] araddr_q,   araddr_d;
    logic [2:0]  outst_cnt_q, outst_cnt_d;
    logic [2:0]  drop_cnt_q,  drop_cnt_d;
    logic        bus_err_q,   bus_err_d;

    logic        w_ar_free;
    logic        w_accept;
    logic        w_r_beat;      // beat matched to an outstanding request
    logic        w_drop_beat;   // matched beat that belongs to a flushed request

    // Single-beat reads: rlast carries no information here.
    logic        w_unused_ok;
    assign w_unused_ok = rlast_i;

    assign arvalid_o = (ar_state_q == AR_BUSY);
    assign araddr_o  = araddr_q;
    assign arid_o    = AXI_ID;
    assign arlen_o   = 8'd0;
    assign arsize_o  = 3'b010;
    assign arburst_o = 2'b01;
    assign rready_o  = 1'b1;

    // The AR register can take a new address when empty or draining this cycle.
    assign w_ar_free = !arvalid_o | arready_i;
    assign w_accept  = inst_sram_req_i & w_ar_free &
                       (outst_cnt_q < C_MAX_OUTST) & !cancel_i;

    // A beat with nothing outstanding is a protocol violation and is not counted.
    assign w_r_beat    = rvalid_i & (outst_cnt_q != 3'd0);
    assign w_drop_beat = w_r_beat & (drop_cnt_q != 3'd0);

    assign inst_sram_addr_ok_o = w_accept;
    assign inst_sram_data_ok_o = rvalid_i & (drop_cnt_q == 3'd0);
    assign inst_sram_rdata_o   = rdata_i;
    assign bus_error_o         = bus_err_q;

    always_comb begin
        ar_state_d  = ar_state_q;
        araddr_d    = araddr_q;
        outst_cnt_d = outst_cnt_q + {2'b00, w_accept} - {2'b00, w_r_beat};
        drop_cnt_d  = drop_cnt_q;
        bus_err_d   = bus_err_q;

        // A new accept reloads the AR register even while the previous
        // address is handing off (arready_i high), so back-to-back is allowed.
        // A flush never withdraws a pending address.
        if (w_accept) begin
            ar_state_d = AR_BUSY;
            araddr_d   = inst_sram_raddr_i;
        end else if (arready_i) begin
            ar_state_d = AR_IDLE;
        end

        // On flush every request still outstanding after this cycle's beat
        // becomes stale. This cycle's beat itself follows the old drop count.
        if (cancel_i) begin
            drop_cnt_d = outst_cnt_q - {2'b00, w_r_beat};
        end else if (w_drop_beat) begin
            drop_cnt_d = drop_cnt_q - 3'd1;
        end

        if (rvalid_i && ((rresp_i != 2'b00) || (outst_cnt_q == 3'd0))) begin
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_state_q  <= AR_IDLE;
            araddr_q    <= 32'd0;
            outst_cnt_q <= 3'd0;
            drop_cnt_q  <= 3'd0;
            bus_err_q   <= 1'b0;
        end else begin
            ar_state_q  <= ar_state_d;
            araddr_q    <= araddr_d;
            outst_cnt_q <= outst_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

`ifdef INST_RBRIDGE_PERF_CNT_EN
    logic [31:0] perf_req_q,   perf_req_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_drop_q,  perf_drop_d;

    always_comb begin
        perf_req_d   = perf_req_q   + {31'd0, w_accept};
        perf_stall_d = perf_stall_q + {31'd0, inst_sram_req_i & !w_accept};
        perf_drop_d  = perf_drop_q  + {31'd0, w_drop_beat};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_req_q   <= 32'd0;
            perf_stall_q <= 32'd0;
            perf_drop_q  <= 32'd0;
        end else begin
            perf_req_q   <= perf_req_d;
            perf_stall_q <= perf_stall_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_req_cnt_o   = perf_req_q;
    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_drop_cnt_o  = perf_drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_sram_axi_rbridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_sram_axi_rbridge
//  Description : Self-checking bench for inst_sram_axi_rbridge: directed
//                vector table, reset sequence and random stimulus compared
//                against a request-queue reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_sram_axi_rbridge;

    localparam int MAX_OUTST = 2;
    localparam logic [31:0] A = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] raddr;
    logic        addr_ok, data_ok;
    logic [31:0] rdata_o;
    logic        cancel;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready, rvalid, rlast, rready, bus_error;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    always #5 clk = ~clk;

    inst_sram_axi_rbridge #(.MAX_OUTST(MAX_OUTST), .AXI_ID(4'd0)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .inst_sram_req_i     (req),
        .inst_sram_raddr_i   (raddr),
        .inst_sram_addr_ok_o (addr_ok),
        .inst_sram_data_ok_o (data_ok),
        .inst_sram_rdata_o   (rdata_o),
        .cancel_i            (cancel),
        .arvalid_o           (arvalid),
        .araddr_o            (araddr),
        .arid_o              (arid),
        .arlen_o             (arlen),
        .arsize_o            (arsize),
        .arburst_o           (arburst),
        .arready_i           (arready),
        .rvalid_i            (rvalid),
        .rdata_i             (rdata),
        .rresp_i             (rresp),
        .rlast_i             (rlast),
        .rready_o            (rready),
        .bus_error_o         (bus_error)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        cancel;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        e_aok;
        logic        e_dok;
        logic        e_arv;
        logic [31:0] e_araddr;
        logic        e_berr;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %08h required %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic i_req, input logic [31:0] i_addr, input logic i_cancel,
                         input logic i_arready, input logic i_rvalid,
                         input logic [31:0] i_rdata, input logic [1:0] i_rresp);
        req     = i_req;
        raddr   = i_addr;
        cancel  = i_cancel;
        arready = i_arready;
        rvalid  = i_rvalid;
        rdata   = i_rdata;
        rresp   = i_rresp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic v(input logic i_req, input logic [31:0] i_addr, input logic i_cancel,
                     input logic i_arready, input logic i_rvalid, input logic [31:0] i_rdata,
                     input logic [1:0] i_rresp, input logic aok, input logic dok,
                     input logic arv, input logic [31:0] ara, input logic berr);
        vec_t t;
        t.req = i_req; t.addr = i_addr; t.cancel = i_cancel; t.arready = i_arready;
        t.rvalid = i_rvalid; t.rdata = i_rdata; t.rresp = i_rresp;
        t.e_aok = aok; t.e_dok = dok; t.e_arv = arv; t.e_araddr = ara; t.e_berr = berr;
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model: one entry per accepted request, flagged stale on flush.
    bit          mq[$];
    bit          m_arv;
    logic [31:0] m_araddr;
    bit          m_berr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic        r_req, r_can, r_ard, r_rv, e_aok, e_dok;
        logic [31:0] r_ad, r_rd;
        logic [1:0]  r_rr;

        rlast = 1'b1;
        do_reset();

        // ---- reset state and constant outputs ----
        #4;
        chk("reset arvalid", 32'(arvalid), 0);
        chk("reset araddr", araddr, 0);
        chk("reset bus_error", 32'(bus_error), 0);
        chk("reset data_ok", 32'(data_ok), 0);
        chk("reset addr_ok", 32'(addr_ok), 0);
        chk("rready const", 32'(rready), 1);
        chk("arid const", 32'(arid), 0);
        chk("arlen const", 32'(arlen), 0);
        chk("arsize const", 32'(arsize), 32'd2);
        chk("arburst const", 32'(arburst), 32'd1);
        tick();

        // ---- directed vector table ----
        //   req addr      can ard rv rdata         rr     aok dok arv araddr    berr
        // single fetch
        v(1, A,          0, 0, 0, 0,            0,     1, 0, 0, 0,        0);
        v(0, 0,          0, 1, 0, 0,            0,     0, 0, 1, A,        0);
        v(0, 0,          0, 0, 0, 0,            0,     0, 0, 0, A,        0);
        v(0, 0,          0, 0, 0, 0,            0,     0, 0, 0, A,        0);
        v(0, 0,          0, 0, 1, 32'h02800C0C, 0,     0, 1, 0, A,        0);
        // back-pressure at MAX_OUTST = 2
        v(1, A,          0, 1, 0, 0,            0,     1, 0, 0, A,        0);
        v(1, A+4,        0, 1, 0, 0,            0,     1, 0, 1, A,        0);
        v(1, A+8,        0, 1, 0, 0,            0,     0, 0, 1, A+4,      0);
        v(1, A+8,        0, 1, 0, 0,            0,     0, 0, 0, A+4,      0);
        v(1, A+8,        0, 1, 1, 32'h11111111, 0,     0, 1, 0, A+4,      0);
        v(1, A+8,        0, 1, 0, 0,            0,     1, 0, 0, A+4,      0);
        v(0, 0,          0, 1, 0, 0,            0,     0, 0, 1, A+8,      0);
        v(0, 0,          0, 1, 1, 32'h22222222, 0,     0, 1, 0, A+8,      0);
        v(0, 0,          0, 1, 1, 32'h33333333, 0,     0, 1, 0, A+8,      0);
        // AR stall: address held for 4 cycles without arready
        v(1, A+32'h10,   0, 0, 0, 0,            0,     1, 0, 0, A+8,      0);
        for (int k = 0; k < 4; k++)
            v(1, A+32'h14, 0, 0, 0, 0,          0,     0, 0, 1, A+32'h10, 0);
        v(1, A+32'h14,   0, 1, 0, 0,            0,     1, 0, 1, A+32'h10, 0);
        v(0, 0,          0, 1, 0, 0,            0,     0, 0, 1, A+32'h14, 0);
        // flush with two outstanding; stale beats dropped, new fetch forwarded
        v(1, A+32'h20,   1, 0, 0, 0,            0,     0, 0, 0, A+32'h14, 0);
        v(0, 0,          0, 0, 1, 32'hAAAAAAAA, 0,     0, 0, 0, A+32'h14, 0);
        v(0, 0,          0, 0, 1, 32'hBBBBBBBB, 0,     0, 0, 0, A+32'h14, 0);
        v(1, A+32'h100,  0, 0, 0, 0,            0,     1, 0, 0, A+32'h14, 0);
        v(0, 0,          0, 1, 0, 0,            0,     0, 0, 1, A+32'h100, 0);
        v(0, 0,          0, 0, 1, 32'hDEADBEEF, 0,     0, 1, 0, A+32'h100, 0);
        // cancel coincident with an R beat
        v(1, A+32'h200,  0, 0, 0, 0,            0,     1, 0, 0, A+32'h100, 0);
        v(1, A+32'h204,  0, 1, 0, 0,            0,     1, 0, 1, A+32'h200, 0);
        v(0, 0,          1, 1, 1, 32'h44444444, 0,     0, 1, 1, A+32'h204, 0);
        v(0, 0,          0, 0, 1, 32'h55555555, 0,     0, 0, 0, A+32'h204, 0);
        v(0, 0,          0, 0, 0, 0,            0,     0, 0, 0, A+32'h204, 0);
        // error response: forwarded, flag sticky
        v(1, A+32'h300,  0, 0, 0, 0,            0,     1, 0, 0, A+32'h204, 0);
        v(0, 0,          0, 1, 0, 0,            0,     0, 0, 1, A+32'h300, 0);
        v(0, 0,          0, 0, 1, 32'h66666666, 2'b10, 0, 1, 0, A+32'h300, 0);
        v(0, 0,          0, 0, 0, 0,            0,     0, 0, 0, A+32'h300, 1);
        v(0, 0,          0, 0, 0, 0,            0,     0, 0, 0, A+32'h300, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].cancel, vecs[i].arready,
                  vecs[i].rvalid, vecs[i].rdata, vecs[i].rresp);
            #4;
            chk($sformatf("vec%0d addr_ok", i), 32'(addr_ok), 32'(vecs[i].e_aok));
            chk($sformatf("vec%0d data_ok", i), 32'(data_ok), 32'(vecs[i].e_dok));
            chk($sformatf("vec%0d arvalid", i), 32'(arvalid), 32'(vecs[i].e_arv));
            chk($sformatf("vec%0d araddr", i), araddr, vecs[i].e_araddr);
            chk($sformatf("vec%0d bus_error", i), 32'(bus_error), 32'(vecs[i].e_berr));
            if (vecs[i].e_dok)
                chk($sformatf("vec%0d rdata", i), rdata_o, vecs[i].rdata);
            tick();
        end

        // ---- randomized run against the queue model ----
        do_reset();
        mq.delete();
        m_arv = 0; m_araddr = 0; m_berr = 0;
        for (int i = 0; i < 2000; i++) begin
            r_req = ($urandom_range(0, 9) < 6);
            r_ad  = A + {$urandom_range(0, 1023), 2'b00};
            r_can = ($urandom_range(0, 9) == 0);
            r_ard = ($urandom_range(0, 1) == 1);
            r_rv  = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
            r_rd  = $urandom;
            r_rr  = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(r_req, r_ad, r_can, r_ard, r_rv, r_rd, r_rr);

            e_aok = r_req && (!m_arv || r_ard) && (mq.size() < MAX_OUTST) && !r_can;
            e_dok = r_rv && !(mq.size() > 0 && mq[0]);
            #4;
            chk($sformatf("rnd%0d addr_ok", i), 32'(addr_ok), 32'(e_aok));
            chk($sformatf("rnd%0d data_ok", i), 32'(data_ok), 32'(e_dok));
            chk($sformatf("rnd%0d arvalid", i), 32'(arvalid), 32'(m_arv));
            chk($sformatf("rnd%0d araddr", i), araddr, m_araddr);
            chk($sformatf("rnd%0d bus_error", i), 32'(bus_error), 32'(m_berr));
            if (e_dok)
                chk($sformatf("rnd%0d rdata", i), rdata_o, r_rd);

            if (r_rv && (r_rr != 2'b00 || mq.size() == 0)) m_berr = 1;
            if (r_rv && mq.size() > 0) void'(mq.pop_front());
            if (r_can) foreach (mq[k]) mq[k] = 1'b1;
            if (e_aok) begin
                mq.push_back(1'b0);
                m_arv    = 1;
                m_araddr = r_ad;
            end else if (r_ard) begin
                m_arv = 0;
            end
            tick();
        end

        // ---- orphan beat: ignored, but flags an error ----
        do_reset();
        drive(0, 0, 0, 0, 1, 32'h77777777, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("orphan bus_error", 32'(bus_error), 1);
        tick();
        // counters untouched: two requests still fit
        drive(1, A+32'h500, 0, 1, 0, 0, 0);
        #4 chk("orphan aok0", 32'(addr_ok), 1);
        tick();
        drive(1, A+32'h504, 0, 1, 0, 0, 0);
        #4 chk("orphan aok1", 32'(addr_ok), 1);
        tick();
        drive(1, A+32'h508, 0, 1, 0, 0, 0);
        #4 chk("orphan aok2 full", 32'(addr_ok), 0);

        // ---- asynchronous reset mid-transaction ----
        drive(1, A+32'h400, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst arvalid", 32'(arvalid), 0);
        chk("async rst araddr", araddr, 0);
        chk("async rst bus_error", 32'(bus_error), 0);
        tick();
        rst_n = 1'b1;
        #4;
        chk("post rst aok0", 32'(addr_ok), 1);
        chk("post rst arvalid", 32'(arvalid), 0);
        tick();
        drive(1, A+32'h404, 0, 1, 0, 0, 0);
        #4;
        chk("post rst aok1", 32'(addr_ok), 1);
        chk("post rst araddr", araddr, A+32'h400);
        tick();
        drive(1, A+32'h408, 0, 1, 0, 0, 0);
        #4;
        chk("post rst aok2 full", 32'(addr_ok), 0);
        chk("post rst araddr2", araddr, A+32'h404);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
